// File: rtl/ccp_pkg.sv
// rtl/ccp_pkg.sv - shared types and constants for the CCP write queue
package ccp_pkg;

    // Default data word width; the queue itself is parameterised separately.
    localparam int CCP_DATA_W = 8;

    // Source tag stored with every queued word.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } ccp_src_t;

    // One queue entry at the default data width.
    typedef struct packed {
        ccp_src_t                src;
        logic [CCP_DATA_W-1:0]   data;
    } ccp_entry_t;

endpackage

// File: rtl/ccp_queue_mem.sv
// rtl/ccp_queue_mem.sv - DEPTH x {src,data} register array, two write ports, one async read port
//   clk            : clock (storage is intentionally not reset)
//   we0/wdata0     : write port 0, slot waddr
//   we1/wdata1     : write port 1, slot waddr+1 (wraps modulo DEPTH)
//   raddr/rdata    : combinational read of slot raddr
module ccp_queue_mem #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we0,
    input  logic [DATA_W:0]   wdata0,
    input  logic              we1,
    input  logic [DATA_W:0]   wdata1,
    input  logic [AW-1:0]     waddr,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W:0]   rdata
);

    logic [DATA_W:0] mem_q [DEPTH];
    logic [DATA_W:0] mem_d [DEPTH];
    logic [AW-1:0]   waddr1;

    // Second slot wraps naturally because AW bits index exactly DEPTH entries.
    assign waddr1 = waddr + AW'(1);

    always_comb begin
        mem_d = mem_q;
        if (we0) begin
            mem_d[waddr] = wdata0;
        end
        if (we1) begin
            mem_d[waddr1] = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ccp_write_queue.sv
// rtl/ccp_write_queue.sv - grant-driven write queue with source tags and ready feedback
//   signalA/dataA, signalB/dataB : enqueue grants (A ordered before B in a cycle)
//   readySignal                  : high while at least two entries are free
//   out_valid/out_ready/out_data/out_src : head-of-queue handshake
//   count                        : occupancy 0..DEPTH
//   overflow                     : sticky, set when any grant is dropped
module ccp_write_queue
    import ccp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     signalA,
    input  logic                     signalB,
    input  logic [DATA_W-1:0]        dataA,
    input  logic [DATA_W-1:0]        dataB,
    output logic                     readySignal,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_src,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            pop;
    logic            acc_a;
    logic            acc_b;
    logic [CW-1:0]   free_slots;
    logic            we0, we1;
    logic [DATA_W:0] wdata0, wdata1;
    logic [DATA_W:0] rd_entry;

    always_comb begin
        pop        = (count_q != '0) && out_ready;
        // A slot vacated by this cycle's pop is usable by this cycle's push.
        free_slots = DEPTH_C - count_q + CW'(pop);
        acc_a      = signalA && (free_slots != '0);
        acc_b      = signalB && (free_slots > (acc_a ? CW'(1) : CW'(0)));

        // Port 0 always takes the first accepted word; port 1 only for B after A.
        we0    = acc_a || acc_b;
        wdata0 = acc_a ? {SRC_A, dataA} : {SRC_B, dataB};
        we1    = acc_a && acc_b;
        wdata1 = {SRC_B, dataB};

        wr_ptr_d   = wr_ptr_q + PW'(acc_a) + PW'(acc_b);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(acc_a) + CW'(acc_b) - CW'(pop);
        overflow_d = overflow_q | (signalA & ~acc_a) | (signalB & ~acc_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    ccp_queue_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we0    (we0),
        .wdata0 (wdata0),
        .we1    (we1),
        .wdata1 (wdata1),
        .waddr  (wr_ptr_q),
        .raddr  (rd_ptr_q),
        .rdata  (rd_entry)
    );

    // Two free slots guarantee a dual grant issued while ready always fits.
    assign readySignal = (count_q <= DEPTH_C - CW'(2));
    assign out_valid   = (count_q != '0);
    assign out_data    = rd_entry[DATA_W-1:0];
    assign out_src     = rd_entry[DATA_W];
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ccp_write_queue.sv
// tb/tb_ccp_write_queue.sv - scoreboard bench for ccp_write_queue
module tb_ccp_write_queue;
    import ccp_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   signalA, signalB;
    logic [DATA_W-1:0]      dataA, dataB;
    logic                   readySignal;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   out_src;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    int tests;
    int fails;

    // Reference model: occupancy queue plus sticky overflow flag.
    ccp_entry_t mq[$];
    ccp_entry_t sb[$];
    bit         m_ovf;

    ccp_write_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signalA     (signalA),
        .signalB     (signalB),
        .dataA       (dataA),
        .dataB       (dataB),
        .readySignal (readySignal),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model applies the queue rules at the edge.
    task automatic cycle(input logic a, input logic b, input logic [7:0] da,
                         input logic [7:0] db, input logic rdy);
        int free;
        ccp_entry_t e;
        signalA   = a;
        signalB   = b;
        dataA     = da;
        dataB     = db;
        out_ready = rdy;
        @(posedge clk);
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        free = DEPTH - mq.size();
        if (a) begin
            if (free > 0) begin
                e.src = SRC_A; e.data = da;
                mq.push_back(e); sb.push_back(e); free--;
            end else m_ovf = 1'b1;
        end
        if (b) begin
            if (free > 0) begin
                e.src = SRC_B; e.data = db;
                mq.push_back(e); sb.push_back(e); free--;
            end else m_ovf = 1'b1;
        end
        #1;
        signalA = 1'b0;
        signalB = 1'b0;
    endtask

    // Monitor: compares the head and status whenever the DUT is out of reset.
    always @(negedge clk) begin
        ccp_entry_t exp_e;
        if (rst_n) begin
            check("count", 32'(count), 32'(mq.size()));
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("readySignal", 32'(readySignal), 32'(mq.size() <= DEPTH - 2));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_head", 32'(out_valid), 32'(0));
                end else begin
                    exp_e = sb[0];
                    check("head_data", 32'(out_data), 32'(exp_e.data));
                    check("head_src", 32'(out_src), 32'(exp_e.src));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        tests = 0; fails = 0; m_ovf = 1'b0;
        rst_n = 1'b0; signalA = 0; signalB = 0; dataA = '0; dataB = '0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset then idle
        cycle(0, 0, 8'h00, 8'h00, 0);
        check("rst_count", 32'(count), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_ready", 32'(readySignal), 32'(1));
        check("rst_ovf", 32'(overflow), 32'(0));

        // Single A word
        cycle(1, 0, 8'h3C, 8'h00, 0);
        check("t1_valid", 32'(out_valid), 32'(1));
        check("t1_data", 32'(out_data), 32'h3C);
        check("t1_src", 32'(out_src), 32'(0));
        check("t1_count", 32'(count), 32'(1));
        cycle(0, 0, 8'h00, 8'h00, 1);
        check("t1_drain", 32'(count), 32'(0));

        // Dual grant into empty queue: A then B
        cycle(1, 1, 8'h11, 8'h22, 0);
        check("t2_count", 32'(count), 32'(2));
        check("t2_first", 32'(out_data), 32'h11);
        cycle(0, 0, 8'h00, 8'h00, 1);
        check("t2_second", 32'(out_data), 32'h22);
        check("t2_src", 32'(out_src), 32'(1));
        cycle(0, 0, 8'h00, 8'h00, 1);

        // Fill to NEAR_FULL, dual grant drops B
        cycle(1, 1, 8'h01, 8'h02, 0);
        cycle(1, 0, 8'h03, 8'h00, 0);
        check("t3_ready_low", 32'(readySignal), 32'(0));
        cycle(1, 1, 8'h04, 8'h05, 0);
        check("t3_full", 32'(count), 32'(4));
        check("t3_ovf", 32'(overflow), 32'(1));

        // FULL with B push and pop: B accepted, 12 entries cross the wrap
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 8'h00, 8'h40 + 8'(i), 1);
            check("t4_count", 32'(count), 32'(4));
        end
        check("t4_ovf", 32'(overflow), 32'(1));
        repeat (5) cycle(0, 0, 8'h00, 8'h00, 1);
        check("t4_empty", 32'(count), 32'(0));
        check("t4_ovf_sticky", 32'(overflow), 32'(1));

        // Reset mid-stream
        cycle(1, 1, 8'h61, 8'h62, 0);
        cycle(1, 0, 8'h63, 8'h00, 0);
        check("t5_pre", 32'(count), 32'(3));
        rst_n = 1'b0;
        signalA = 1'b1; dataA = 8'hFF;
        mq.delete(); sb.delete(); m_ovf = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'(0));
        check("t5_count", 32'(count), 32'(0));
        check("t5_ready", 32'(readySignal), 32'(1));
        check("t5_ovf", 32'(overflow), 32'(0));
        @(posedge clk);
        #1;
        check("t5_grant_ignored", 32'(count), 32'(0));
        signalA = 1'b0;
        rst_n = 1'b1;
        cycle(1, 0, 8'hA5, 8'h00, 0);
        check("t5_first", 32'(out_data), 32'hA5);
        check("t5_first_src", 32'(out_src), 32'(0));
        cycle(0, 0, 8'h00, 8'h00, 1);

        // Randomized traffic, mostly respecting readySignal
        for (int i = 0; i < 800; i++) begin
            logic a, b, r;
            bit obey;
            obey = ($urandom_range(0, 9) < 8);
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (obey && !readySignal) begin a = 1'b0; b = 1'b0; end
            r = ($urandom_range(0, 9) < 6);
            cycle(a, b, 8'($urandom), 8'($urandom), r);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 8'h00, 8'h00, 1);
        check("final_empty", 32'(count), 32'(0));
        check("final_sb", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
